// File: rtl/neurram_pkg.sv
// rtl/neurram_pkg.sv - shared state encoding and chain constants for the NeuRRAM readback path
package neurram_pkg;

  typedef enum logic [2:0] {
    READBACK_IDLE   = 3'd0,
    READBACK_CLK_LO = 3'd1,
    READBACK_CLK_HI = 3'd2,
    READBACK_PUSH   = 3'd3,
    READBACK_DONE   = 3'd4
  } readback_state_t;

  localparam logic CHAIN0 = 1'b0;
  localparam logic CHAIN1 = 1'b1;

  localparam int READBACK_WORD_W = 32;

endpackage

// File: rtl/neurram_spi_clk_gen.sv
// rtl/neurram_spi_clk_gen.sv - registered shift-clock generator with phase strobes and stall hold
module neurram_spi_clk_gen
  import neurram_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  input  logic       sel,
  output logic [1:0] spi_clk,
  output logic       phase_end,
  output logic       rise,
  output logic       fall
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PH_W-1:0] ph_cnt;
  logic            run;
  logic            level;

  assign run       = en && !hold;
  assign level     = spi_clk[0] | spi_clk[1];
  assign phase_end = run && (ph_cnt == PH_W'(CLK_DIV - 1));
  assign rise      = phase_end && !level;
  assign fall      = phase_end && level;

  // Idle or stalled: phase restarts from zero with the clock parked low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt  <= '0;
      spi_clk <= 2'b00;
    end else if (!run) begin
      ph_cnt  <= '0;
      spi_clk <= 2'b00;
    end else if (phase_end) begin
      ph_cnt  <= '0;
      spi_clk <= (sel == CHAIN1) ? {!level, 1'b0} : {1'b0, !level};
    end else begin
      ph_cnt  <= ph_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/neurram_reg_readback.sv
// rtl/neurram_reg_readback.sv - shifts one NeuRRAM chain out over spi_clk/sdo and packs it into words
// Define NEURRAM_READBACK_PARITY_EN to add the parity output (XOR of all bits read).
module neurram_reg_readback
  import neurram_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = READBACK_WORD_W,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              chain_sel,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic [1:0]        sdo_in,
  output logic [1:0]        spi_clk_out,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
`ifdef NEURRAM_READBACK_PARITY_EN
  ,
  output logic              parity
`endif
);

  localparam int WC_W = $clog2(WORD_W + 1);

  readback_state_t   state_q, state_d;
  logic              sel_q;
  logic [CNT_W-1:0]  num_q, bit_cnt, bit_cnt_inc;
  logic [WC_W-1:0]   word_cnt, word_cnt_inc;
  logic [WORD_W-1:0] shreg, shreg_nx;
  logic              sdo_bit, last_bit, word_full, all_read;
  logic              clk_hold, phase_end, rise, fall;

  assign sdo_bit      = (sel_q == CHAIN0) ? sdo_in[0] : sdo_in[1];
  assign bit_cnt_inc  = bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign word_cnt_inc = word_cnt + {{(WC_W-1){1'b0}}, 1'b1};
  assign shreg_nx     = {shreg[WORD_W-2:0], sdo_bit};
  assign last_bit     = (bit_cnt_inc == num_q);
  assign word_full    = (word_cnt_inc == WC_W'(WORD_W));
  assign all_read     = (bit_cnt == num_q);
  assign busy         = (state_q != READBACK_IDLE);
  assign done         = (state_q == READBACK_DONE);
  assign clk_hold     = (state_q == READBACK_PUSH) || (state_q == READBACK_DONE);

  neurram_spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (busy),
    .hold      (clk_hold),
    .sel       (sel_q),
    .spi_clk   (spi_clk_out),
    .phase_end (phase_end),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= READBACK_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READBACK_IDLE:   if (start) state_d = (num_bits == '0) ? READBACK_DONE : READBACK_CLK_LO;
      READBACK_CLK_LO: if (rise) state_d = READBACK_CLK_HI;
      READBACK_CLK_HI: if (phase_end) state_d = (word_full || last_bit) ? READBACK_PUSH : READBACK_CLK_LO;
      READBACK_PUSH:   if (word_ready) state_d = all_read ? READBACK_DONE : READBACK_CLK_LO;
      READBACK_DONE:   state_d = READBACK_IDLE;
      default:         state_d = READBACK_IDLE;
    endcase
  end

  // sdo is sampled on the last high cycle, while the chip still holds it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= CHAIN0;
      num_q      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      case (state_q)
        READBACK_IDLE: begin
          if (start) begin
            sel_q    <= chain_sel;
            num_q    <= num_bits;
            bit_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
          end
        end
        READBACK_CLK_HI: begin
          if (fall) begin
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_inc;
            word_cnt <= word_cnt_inc;
            if (word_full || last_bit) begin
              word_data  <= shreg_nx;
              word_valid <= 1'b1;
            end
          end
        end
        READBACK_PUSH: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            word_cnt   <= '0;
            shreg      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NEURRAM_READBACK_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (state_q == READBACK_IDLE && start) begin
      parity <= 1'b0;
    end else if (state_q == READBACK_CLK_HI && fall) begin
      parity <= parity ^ sdo_bit;
    end
  end
`endif

endmodule
